// File: rtl/sm83_flags_pkg.sv
// Shared types for the SM83 flag-op sequencer: op classes, sequencer states
// and the bundle of flags-unit strobes.
package sm83_flags_pkg;

  localparam int OP_W = 5;

  typedef enum logic [OP_W-1:0] {
    NOP, ADD, ADC, SUB, SBC, CP, LOGIC, INC, DEC, SHIFT,
    BIT, CPL, SCF, CCF, DAA, ADD16, POPAF
  } flag_op_t;

  typedef logic [1:0] seq_state_t;
  localparam seq_state_t ST_IDLE = 2'd0;
  localparam seq_state_t ST_S0   = 2'd1;
  localparam seq_state_t ST_S1   = 2'd2;

  typedef struct packed {
    logic flags_bus;
    logic flags_alu;
    logic zero_we;
    logic half_carry_we;
    logic daa_carry_we;
    logic neg_we;
    logic neg_set;
    logic neg_clr;
    logic carry_we;
    logic sec_carry_we;
    logic sec_carry_sh;
    logic sec_carry_daa;
    logic carry_set;
    logic carry_cpl;
  } flag_ctl_t;

  // Ops whose final step leaves the secondary carry as the live carry source.
  function automatic logic sets_sticky(flag_op_t op);
    return (op == SHIFT) || (op == DAA);
  endfunction

endpackage

// File: rtl/sm83_flags_seq_if.sv
// Decoder-to-sequencer handshake plus the strobes driven into the flags unit.
interface sm83_flags_seq_if;
  import sm83_flags_pkg::*;

  logic     start;
  flag_op_t op;
  logic     ready;
  logic     done;
  logic     step;
  logic     flags_bus;
  logic     flags_alu;
  logic     zero_we;
  logic     half_carry_we;
  logic     daa_carry_we;
  logic     neg_we;
  logic     neg_set;
  logic     neg_clr;
  logic     carry_we;
  logic     sec_carry_we;
  logic     sec_carry_sh;
  logic     sec_carry_daa;
  logic     sec_carry_sel;
  logic     carry_set;
  logic     carry_cpl;

  modport master (
    output start, op,
    input  ready, done, step, flags_bus, flags_alu, zero_we, half_carry_we,
           daa_carry_we, neg_we, neg_set, neg_clr, carry_we, sec_carry_we,
           sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl
  );

  modport slave (
    input  start, op,
    output ready, done, step, flags_bus, flags_alu, zero_we, half_carry_we,
           daa_carry_we, neg_we, neg_set, neg_clr, carry_we, sec_carry_we,
           sec_carry_sh, sec_carry_daa, sec_carry_sel, carry_set, carry_cpl
  );
endinterface

// File: rtl/sm83_flags_seq_decode.sv
// Combinational op-class decode: (op, step) -> flags-unit strobes and step count.
module sm83_flags_seq_decode
  import sm83_flags_pkg::*;
(
  input  flag_op_t  op,
  input  logic      step,
  output flag_ctl_t ctl,
  output logic      two_step
);

  always_comb begin
    ctl       = '0;
    two_step  = 1'b0;
    ctl.flags_alu = (op != NOP) && (op != POPAF);
    case (op)
      ADD, ADC: begin
        {ctl.zero_we, ctl.half_carry_we, ctl.carry_we, ctl.daa_carry_we} = 4'b1111;
        {ctl.neg_we, ctl.neg_clr} = 2'b11;
      end
      SUB, SBC, CP: begin
        {ctl.zero_we, ctl.half_carry_we, ctl.carry_we, ctl.daa_carry_we} = 4'b1111;
        {ctl.neg_we, ctl.neg_set} = 2'b11;
      end
      LOGIC: begin
        {ctl.zero_we, ctl.half_carry_we, ctl.carry_we} = 3'b111;
        {ctl.neg_we, ctl.neg_clr} = 2'b11;
      end
      INC, BIT: begin
        {ctl.zero_we, ctl.half_carry_we} = 2'b11;
        {ctl.neg_we, ctl.neg_clr} = 2'b11;
      end
      DEC: begin
        {ctl.zero_we, ctl.half_carry_we} = 2'b11;
        {ctl.neg_we, ctl.neg_set} = 2'b11;
      end
      SHIFT: begin
        {ctl.zero_we, ctl.half_carry_we} = 2'b11;
        {ctl.neg_we, ctl.neg_clr} = 2'b11;
        {ctl.sec_carry_we, ctl.sec_carry_sh} = 2'b11;
      end
      CPL: begin
        ctl.half_carry_we = 1'b1;
        {ctl.neg_we, ctl.neg_set} = 2'b11;
      end
      SCF, CCF: begin
        {ctl.half_carry_we, ctl.carry_we} = 2'b11;
        {ctl.neg_we, ctl.neg_clr} = 2'b11;
        ctl.carry_set = (op == SCF);
        ctl.carry_cpl = (op == CCF);
      end
      DAA: begin
        two_step = 1'b1;
        if (step) begin
          {ctl.zero_we, ctl.half_carry_we} = 2'b11;
        end else begin
          {ctl.sec_carry_we, ctl.sec_carry_daa} = 2'b11;
        end
      end
      ADD16: begin
        two_step = 1'b1;
        ctl.carry_we = 1'b1;
        if (step) begin
          ctl.half_carry_we = 1'b1;
          {ctl.neg_we, ctl.neg_clr} = 2'b11;
        end
      end
      POPAF: begin
        ctl.flags_bus = 1'b1;
        {ctl.zero_we, ctl.neg_we, ctl.half_carry_we, ctl.carry_we, ctl.daa_carry_we} = 5'b11111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/sm83_flags_seq.sv
// SM83 flag-op sequencer: FSM, op latch and sticky secondary-carry select.
// Optional SM83_FLAGS_SEQ_ABORT_EN adds an abort input that kills the current step.
//
// state   | meaning
// IDLE    | ready, waiting for start
// S0      | first (low-byte) step strobing
// S1      | second (high-byte) step of a two-step op
module sm83_flags_seq
  import sm83_flags_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
`ifdef SM83_FLAGS_SEQ_ABORT_EN
  input  logic abort,
`endif
  sm83_flags_seq_if.slave fif
);

  seq_state_t state_q, state_d;
  flag_op_t   op_q;
  logic       sticky_q;
  flag_ctl_t  ctl_dec, ctl;
  logic       two_step, step_i, active, done_i, abort_i;

`ifdef SM83_FLAGS_SEQ_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  assign step_i = (state_q == ST_S1);
  assign active = (state_q != ST_IDLE) && !abort_i;

  sm83_flags_seq_decode u_decode (
    .op       (op_q),
    .step     (step_i),
    .ctl      (ctl_dec),
    .two_step (two_step)
  );

  assign ctl    = active ? ctl_dec : '0;
  assign done_i = active && (step_i || !two_step);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fif.start) state_d = ST_S0;
      ST_S0:   state_d = (two_step && !abort_i) ? ST_S1 : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      op_q     <= NOP;
      sticky_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && fif.start) op_q <= fif.op;
      // Carry writes take priority; SHIFT/DAA final steps never write carry.
      if (active) begin
        if (ctl.carry_we)                      sticky_q <= 1'b0;
        else if (done_i && sets_sticky(op_q))  sticky_q <= 1'b1;
      end
    end
  end

  assign fif.ready         = (state_q == ST_IDLE);
  assign fif.done          = done_i;
  assign fif.step          = step_i;
  assign fif.sec_carry_sel = sticky_q;
  assign fif.flags_bus     = ctl.flags_bus;
  assign fif.flags_alu     = ctl.flags_alu;
  assign fif.zero_we       = ctl.zero_we;
  assign fif.half_carry_we = ctl.half_carry_we;
  assign fif.daa_carry_we  = ctl.daa_carry_we;
  assign fif.neg_we        = ctl.neg_we;
  assign fif.neg_set       = ctl.neg_set;
  assign fif.neg_clr       = ctl.neg_clr;
  assign fif.carry_we      = ctl.carry_we;
  assign fif.sec_carry_we  = ctl.sec_carry_we;
  assign fif.sec_carry_sh  = ctl.sec_carry_sh;
  assign fif.sec_carry_daa = ctl.sec_carry_daa;
  assign fif.carry_set     = ctl.carry_set;
  assign fif.carry_cpl     = ctl.carry_cpl;

endmodule

// File: tb/tb_sm83_flags_seq.sv
// Randomized self-checking bench for sm83_flags_seq against an op-table reference model.
module tb_sm83_flags_seq;
  import sm83_flags_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sm83_flags_seq_if fif();

`ifdef SM83_FLAGS_SEQ_ABORT_EN
  logic abort;
  sm83_flags_seq dut (.clk(clk), .reset_n(reset_n), .abort(abort), .fif(fif));
`else
  sm83_flags_seq dut (.clk(clk), .reset_n(reset_n), .fif(fif));
`endif

  int   n_tests = 0;
  int   n_fail  = 0;
  logic model_sticky = 1'b0;

  // Strobe bit positions in the packed comparison vector.
  localparam logic [13:0] M_BUS = 14'b1 << 13, M_ALU = 14'b1 << 12, M_Z  = 14'b1 << 11,
                          M_H   = 14'b1 << 10, M_D   = 14'b1 << 9,  M_NW = 14'b1 << 8,
                          M_NS  = 14'b1 << 7,  M_NC  = 14'b1 << 6,  M_C  = 14'b1 << 5,
                          M_SW  = 14'b1 << 4,  M_SSH = 14'b1 << 3,  M_SDA = 14'b1 << 2,
                          M_CS  = 14'b1 << 1,  M_CC  = 14'b1;

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [13:0] dut_ctl();
    return {fif.flags_bus, fif.flags_alu, fif.zero_we, fif.half_carry_we, fif.daa_carry_we,
            fif.neg_we, fif.neg_set, fif.neg_clr, fif.carry_we, fif.sec_carry_we,
            fif.sec_carry_sh, fif.sec_carry_daa, fif.carry_set, fif.carry_cpl};
  endfunction

  function automatic int n_steps(flag_op_t o);
    return (o == DAA || o == ADD16) ? 2 : 1;
  endfunction

  function automatic logic [13:0] exp_ctl(flag_op_t o, int s);
    case (o)
      ADD, ADC:     return M_ALU | M_Z | M_H | M_C | M_D | M_NW | M_NC;
      SUB, SBC, CP: return M_ALU | M_Z | M_H | M_C | M_D | M_NW | M_NS;
      LOGIC:        return M_ALU | M_Z | M_H | M_C | M_NW | M_NC;
      INC, BIT:     return M_ALU | M_Z | M_H | M_NW | M_NC;
      DEC:          return M_ALU | M_Z | M_H | M_NW | M_NS;
      SHIFT:        return M_ALU | M_Z | M_H | M_NW | M_NC | M_SW | M_SSH;
      CPL:          return M_ALU | M_H | M_NW | M_NS;
      SCF:          return M_ALU | M_H | M_C | M_NW | M_NC | M_CS;
      CCF:          return M_ALU | M_H | M_C | M_NW | M_NC | M_CC;
      DAA:          return (s == 0) ? (M_ALU | M_SW | M_SDA) : (M_ALU | M_Z | M_H);
      ADD16:        return (s == 0) ? (M_ALU | M_C) : (M_ALU | M_H | M_C | M_NW | M_NC);
      POPAF:        return M_BUS | M_Z | M_NW | M_H | M_C | M_D;
      default:      return 14'd0;
    endcase
  endfunction

  task automatic drive_abort(logic a);
`ifdef SM83_FLAGS_SEQ_ABORT_EN
    abort = a;
`endif
  endtask

  task automatic idle_check(string tag);
    @(negedge clk); #1;
    check_eq({tag, "_ready"}, fif.ready, 1'b1);
    check_eq({tag, "_ctl"}, dut_ctl(), 14'd0);
    check_eq({tag, "_done"}, fif.done, 1'b0);
    check_eq({tag, "_sel"}, fif.sec_carry_sel, model_sticky);
  endtask

  // abort_step: -1 never, -2 random, otherwise the step index to abort.
  task automatic run_op(flag_op_t o, bit hold, int abort_step);
    logic [13:0] e;
    bit ab;
    int n;
    n = n_steps(o);
    fif.start = 1'b1;
    fif.op    = o;
    @(posedge clk); #1;
    if (hold) fif.op = flag_op_t'($urandom_range(0, 16));
    else      fif.start = 1'b0;
    for (int s = 0; s < n; s++) begin
      @(negedge clk);
      ab = 1'b0;
`ifdef SM83_FLAGS_SEQ_ABORT_EN
      ab = (abort_step == s) || (abort_step == -2 && $urandom_range(0, 5) == 0);
`endif
      drive_abort(ab);
      #1;
      e = ab ? 14'd0 : exp_ctl(o, s);
      check_eq({o.name(), "_ctl"}, dut_ctl(), e);
      check_eq({o.name(), "_done"}, fif.done, !ab && (s == n - 1));
      check_eq({o.name(), "_step"}, fif.step, s == 1);
      check_eq({o.name(), "_ready"}, fif.ready, 1'b0);
      check_eq({o.name(), "_sel"}, fif.sec_carry_sel, model_sticky);
      @(posedge clk); #1;
      drive_abort(1'b0);
      if (ab) break;
      if (e & M_C)                                 model_sticky = 1'b0;
      else if (s == n - 1 && (o == SHIFT || o == DAA)) model_sticky = 1'b1;
    end
    fif.start = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    fif.start = 1'b0;
    fif.op    = NOP;
    drive_abort(1'b0);
    #12;
    check_eq("rst_ready", fif.ready, 1'b1);
    check_eq("rst_ctl", dut_ctl(), 14'd0);
    check_eq("rst_done", fif.done, 1'b0);
    check_eq("rst_sel", fif.sec_carry_sel, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    idle_check("idle0");

    run_op(SUB, 1'b0, -1);   idle_check("post_sub");
    run_op(SHIFT, 1'b0, -1); idle_check("post_shift");
    run_op(ADD, 1'b0, -1);   idle_check("post_add");
    run_op(DAA, 1'b0, -1);   idle_check("post_daa");
    run_op(ADD16, 1'b1, -1);
    run_op(ADD16, 1'b0, -1); idle_check("post_add16");
    run_op(SHIFT, 1'b0, -1);
    run_op(POPAF, 1'b0, -1); idle_check("post_popaf");
    run_op(SHIFT, 1'b0, -1);
    run_op(SCF, 1'b0, -1);
    run_op(NOP, 1'b0, -1);   idle_check("post_nop");
`ifdef SM83_FLAGS_SEQ_ABORT_EN
    run_op(DAA, 1'b0, 0);    idle_check("post_abort");
`endif

    // Reset landing in the second step of ADD16.
    run_op(SHIFT, 1'b0, -1);
    fif.start = 1'b1;
    fif.op    = ADD16;
    @(posedge clk); #1;
    fif.start = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    check_eq("mid_s1_ctl", dut_ctl(), exp_ctl(ADD16, 1));
    reset_n = 1'b0;
    #1;
    check_eq("mid_rst_ctl", dut_ctl(), 14'd0);
    check_eq("mid_rst_done", fif.done, 1'b0);
    check_eq("mid_rst_ready", fif.ready, 1'b1);
    check_eq("mid_rst_sel", fif.sec_carry_sel, 1'b0);
    #1;
    reset_n = 1'b1;
    model_sticky = 1'b0;
    idle_check("post_mid_rst");

    repeat (300) begin
      run_op(flag_op_t'($urandom_range(0, 16)), 1'($urandom_range(0, 1)), -2);
      repeat ($urandom_range(0, 2)) idle_check("gap");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
